// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the shared RAM and dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and RAM.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic              stall;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_q,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_addr, ram_wdata, ram_wren, stall
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_q,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_addr, ram_wdata, ram_wren, stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: port 0 (MEM stage) has priority,
// bounded by a starvation counter so port 1 (debug/loader) always makes progress.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              p0_gnt_s;
    logic              p1_gnt_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              ram_wren_s;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        wait_cnt_nxt_s;
    logic              rd_pend_r;
    logic              rd_pend_nxt_s;
    logic              rd_owner_r;
    logic              rd_owner_nxt_s;
    logic              p0_rvalid_s;
    logic              p1_rvalid_s;

    // Grant selection: port 0 wins ties until port 1 has waited STARVE_MAX cycles
    always_comb begin
        p0_gnt_s = 1'b0;
        p1_gnt_s = 1'b0;
        case ({bus.p0_req, bus.p1_req})
            2'b10: p0_gnt_s = 1'b1;
            2'b01: p1_gnt_s = 1'b1;
            2'b11: begin
                if (wait_cnt_r == STARVE_LIM) begin
                    p1_gnt_s = 1'b1;
                end else begin
                    p0_gnt_s = 1'b1;
                end
            end
            default: begin
                p0_gnt_s = 1'b0;
                p1_gnt_s = 1'b0;
            end
        endcase
    end

    // RAM port mux driven by the granted requester, zeros when idle
    always_comb begin
        ram_addr_s  = {ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        ram_wren_s  = 1'b0;
        if (p0_gnt_s) begin
            ram_addr_s  = bus.p0_addr;
            ram_wdata_s = bus.p0_wdata;
            ram_wren_s  = bus.p0_we;
        end else if (p1_gnt_s) begin
            ram_addr_s  = bus.p1_addr;
            ram_wdata_s = bus.p1_wdata;
            ram_wren_s  = bus.p1_we;
        end else begin
            ram_addr_s  = {ADDR_W{1'b0}};
            ram_wdata_s = {DATA_W{1'b0}};
            ram_wren_s  = 1'b0;
        end
    end

    // Next-state: saturating starvation count and read-return tracking
    always_comb begin
        wait_cnt_nxt_s = 4'd0;
        if (bus.p1_req && !p1_gnt_s) begin
            if (wait_cnt_r == STARVE_LIM) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + 4'd1;
            end
        end else begin
            wait_cnt_nxt_s = 4'd0;
        end
        rd_pend_nxt_s  = (p0_gnt_s & ~bus.p0_we) | (p1_gnt_s & ~bus.p1_we);
        rd_owner_nxt_s = p1_gnt_s;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            rd_pend_r  <= rd_pend_nxt_s;
            rd_owner_r <= rd_owner_nxt_s;
        end
    end

    // The async reset clears rd_pend, so any in-flight read return is dropped at once
    assign p0_rvalid_s   = rd_pend_r & ~rd_owner_r;
    assign p1_rvalid_s   = rd_pend_r & rd_owner_r;

    assign bus.p0_gnt    = p0_gnt_s;
    assign bus.p1_gnt    = p1_gnt_s;
    assign bus.p0_rvalid = p0_rvalid_s;
    assign bus.p1_rvalid = p1_rvalid_s;
    assign bus.p0_rdata  = p0_rvalid_s ? bus.ram_q : {DATA_W{1'b0}};
    assign bus.p1_rdata  = p1_rvalid_s ? bus.ram_q : {DATA_W{1'b0}};
    assign bus.ram_addr  = ram_addr_s;
    assign bus.ram_wdata = ram_wdata_s;
    assign bus.ram_wren  = ram_wren_s & rst_n;
    assign bus.stall     = bus.p0_req & ~p0_gnt_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a write-first 256x32 RAM model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    logic [31:0] mem [256];
    logic [7:0]  pre_addr [3];
    logic [31:0] pre_data [3];

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_q         <= bus.ram_wdata;
        end else begin
            bus.ram_q         <= mem[bus.ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wd);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wd);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Port 0 held, port 1 raised at cycle 0: port 1 must win at cycle 4 only
    task automatic run_starve(input string tag);
        set_p0(1'b1, 1'b0, 8'h10, 32'h0);
        set_p1(1'b1, 1'b0, 8'h31, 32'h0);
        for (int c = 0; c < 5; c++) begin
            smp();
            chk1({tag, "_p0_gnt"}, bus.p0_gnt, (c < 4) ? 1'b1 : 1'b0);
            chk1({tag, "_p1_gnt"}, bus.p1_gnt, (c == 4) ? 1'b1 : 1'b0);
            chk1({tag, "_stall"},  bus.stall,  (c == 4) ? 1'b1 : 1'b0);
            tick();
        end
        set_p1(1'b0, 1'b0, 8'h0, 32'h0);
        smp();
        chk1({tag, "_c5_p0_gnt"}, bus.p0_gnt, 1'b1);
        chk1({tag, "_c5_p1_gnt"}, bus.p1_gnt, 1'b0);
        chk1({tag, "_c5_stall"},  bus.stall,  1'b0);
        chk1({tag, "_c5_p1_rvalid"}, bus.p1_rvalid, 1'b1);
        tick();
    endtask

    initial begin
        pre_addr[0] = 8'h01; pre_data[0] = 32'hA5A5_0001;
        pre_addr[1] = 8'h20; pre_data[1] = 32'h0000_0011;
        pre_addr[2] = 8'h21; pre_data[2] = 32'h0000_0022;
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        set_p1(1'b0, 1'b0, 8'h00, 32'h0);
        #2;
        // Reset: grants still follow requests, write enable forced low
        chk1 ("rst_p0_rvalid", bus.p0_rvalid, 1'b0);
        chk1 ("rst_p1_rvalid", bus.p1_rvalid, 1'b0);
        chk32("rst_p0_rdata",  bus.p0_rdata, 32'h0);
        chk32("rst_p1_rdata",  bus.p1_rdata, 32'h0);
        chk1 ("rst_wren",      bus.ram_wren, 1'b0);
        chk1 ("rst_p0_gnt",    bus.p0_gnt,   1'b1);
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        rst_n = 1'b1;
        tick();

        // Port 0 only: write then read back
        set_p0(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        smp();
        chk1 ("t1w_p0_gnt", bus.p0_gnt, 1'b1);
        chk1 ("t1w_stall",  bus.stall,  1'b0);
        chk1 ("t1w_wren",   bus.ram_wren, 1'b1);
        chk32("t1w_addr",   {24'h0, bus.ram_addr}, 32'h10);
        chk32("t1w_wdata",  bus.ram_wdata, 32'hDEAD_BEEF);
        tick();
        set_p0(1'b1, 1'b0, 8'h10, 32'h0);
        smp();
        chk1 ("t1r_p0_gnt",    bus.p0_gnt, 1'b1);
        chk1 ("t1r_stall",     bus.stall,  1'b0);
        chk1 ("t1r_wren",      bus.ram_wren, 1'b0);
        chk1 ("t1r_no_rvalid", bus.p0_rvalid, 1'b0);
        tick();
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        chk1 ("t1_p0_rvalid", bus.p0_rvalid, 1'b1);
        chk32("t1_p0_rdata",  bus.p0_rdata, 32'hDEAD_BEEF);
        chk1 ("t1_p1_rvalid", bus.p1_rvalid, 1'b0);
        chk32("t1_p1_rdata",  bus.p1_rdata, 32'h0);
        tick();
        smp();
        chk1 ("t1_rvalid_pulse", bus.p0_rvalid, 1'b0);
        chk32("t1_rdata_idle",   bus.p0_rdata, 32'h0);
        tick();

        for (int i = 0; i < 3; i++) begin
            set_p0(1'b1, 1'b1, pre_addr[i], pre_data[i]);
            tick();
        end
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);

        // Simultaneous one-shot requests, then read-after-write of p1's data
        set_p0(1'b1, 1'b0, 8'h01, 32'h0);
        set_p1(1'b1, 1'b1, 8'h02, 32'h0000_0202);
        smp();
        chk1("t2c0_p0_gnt", bus.p0_gnt, 1'b1);
        chk1("t2c0_p1_gnt", bus.p1_gnt, 1'b0);
        chk1("t2c0_stall",  bus.stall,  1'b0);
        tick();
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        chk1 ("t2c1_p1_gnt",    bus.p1_gnt, 1'b1);
        chk1 ("t2c1_p0_gnt",    bus.p0_gnt, 1'b0);
        chk1 ("t2c1_wren",      bus.ram_wren, 1'b1);
        chk1 ("t2c1_p0_rvalid", bus.p0_rvalid, 1'b1);
        chk32("t2c1_p0_rdata",  bus.p0_rdata, 32'hA5A5_0001);
        chk1 ("t2c1_p1_rvalid", bus.p1_rvalid, 1'b0);
        tick();
        set_p1(1'b0, 1'b0, 8'h00, 32'h0);
        set_p0(1'b1, 1'b0, 8'h02, 32'h0);
        smp();
        chk1("t2c2_p0_gnt",    bus.p0_gnt, 1'b1);
        chk1("t2c2_p1_rvalid", bus.p1_rvalid, 1'b0);
        tick();
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        chk1 ("t2_raw_rvalid", bus.p0_rvalid, 1'b1);
        chk32("t2_raw_rdata",  bus.p0_rdata, 32'h0000_0202);
        tick();

        run_starve("starve");
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        tick();

        // Alternating read ownership
        set_p1(1'b1, 1'b0, 8'h20, 32'h0);
        smp();
        chk1("t4c0_p1_gnt", bus.p1_gnt, 1'b1);
        tick();
        set_p1(1'b0, 1'b0, 8'h00, 32'h0);
        set_p0(1'b1, 1'b0, 8'h21, 32'h0);
        smp();
        chk1 ("t4c1_p0_gnt",    bus.p0_gnt, 1'b1);
        chk1 ("t4c1_p1_rvalid", bus.p1_rvalid, 1'b1);
        chk32("t4c1_p1_rdata",  bus.p1_rdata, 32'h0000_0011);
        chk1 ("t4c1_p0_rvalid", bus.p0_rvalid, 1'b0);
        chk32("t4c1_p0_rdata",  bus.p0_rdata, 32'h0);
        tick();
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        chk1 ("t4c2_p0_rvalid", bus.p0_rvalid, 1'b1);
        chk32("t4c2_p0_rdata",  bus.p0_rdata, 32'h0000_0022);
        chk1 ("t4c2_p1_rvalid", bus.p1_rvalid, 1'b0);
        chk32("t4c2_p1_rdata",  bus.p1_rdata, 32'h0);
        tick();

        // Saturate the count with a p0 read pending, then reset asynchronously
        set_p0(1'b1, 1'b0, 8'h10, 32'h0);
        set_p1(1'b1, 1'b0, 8'h31, 32'h0);
        for (int c = 0; c < 4; c++) begin
            smp();
            chk1("t5_pre_p0_gnt", bus.p0_gnt, 1'b1);
            tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk1 ("t5_rst_p0_rvalid", bus.p0_rvalid, 1'b0);
        chk32("t5_rst_p0_rdata",  bus.p0_rdata, 32'h0);
        chk1 ("t5_rst_p0_gnt",    bus.p0_gnt, 1'b1);
        chk1 ("t5_rst_p1_gnt",    bus.p1_gnt, 1'b0);
        chk1 ("t5_rst_wren",      bus.ram_wren, 1'b0);
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        set_p1(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        tick();
        smp();
        chk1("t5_inrst_p0_rvalid", bus.p0_rvalid, 1'b0);
        rst_n = 1'b1;
        tick();
        smp();
        chk1("t5_post_p0_rvalid", bus.p0_rvalid, 1'b0);
        chk1("t5_post_p1_rvalid", bus.p1_rvalid, 1'b0);
        tick();
        run_starve("starve_rst");
        set_p0(1'b0, 1'b0, 8'h00, 32'h0);
        smp();
        tick();

        // Idle
        for (int c = 0; c < 10; c++) begin
            smp();
            chk1 ("idle_wren",      bus.ram_wren, 1'b0);
            chk32("idle_addr",      {24'h0, bus.ram_addr}, 32'h0);
            chk1 ("idle_p0_gnt",    bus.p0_gnt, 1'b0);
            chk1 ("idle_p1_gnt",    bus.p1_gnt, 1'b0);
            chk1 ("idle_p0_rvalid", bus.p0_rvalid, 1'b0);
            chk1 ("idle_p1_rvalid", bus.p1_rvalid, 1'b0);
            chk1 ("idle_stall",     bus.stall, 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
